lfsr_word_scheduler: RTL and testbench

Controller that shares one 4-bit LFSR generator cell among `NREQ` requesters. It arbitrates round-robin, loads the winner's seed into the LFSR and clocks the cell for `WORD_W` cycles, collecting the serial output into a word. It returns that word to the winner through a valid/ready handshake. It sits between the requester ports and the LFSR cell, and is the only driver of the cell's load and seed inputs.

---
 rtl/lfsr_word_scheduler_pkg.sv | 29 ++
 rtl/lfsr_word_scheduler_rr_arbiter.sv | 36 +++
 rtl/lfsr_word_scheduler.sv | 113 +++++++++++
 tb/tb_lfsr_word_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_word_scheduler_pkg.sv
// Shared definitions for the LFSR word scheduler: FSM encoding, seed
// sanitizing and the width helper used to size counters and indices.
package lfsr_word_scheduler_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] SEED_DEFAULT = 4'b0001;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // An all-zero state locks the LFSR up, so it is never loaded.
    function automatic logic [3:0] sanitize_seed(input logic [3:0] s);
        return (s == 4'h0) ? SEED_DEFAULT : s;
    endfunction

endpackage

// File: rtl/lfsr_word_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the
// pointer, wrapping around, reported as one-hot plus index.
module rr_arbiter
    import lfsr_word_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_vld && req[cand]) begin
                grant_vld   = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_word_scheduler.sv
// Shares one external 4-bit LFSR cell among NREQ requesters: arbitrates,
// seeds the cell, collects WORD_W serial bits and hands the word back.
module lfsr_word_scheduler
    import lfsr_word_scheduler_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    localparam int IDX_W = clog2(NREQ)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   seed,
    output logic [NREQ-1:0]     gnt,
    output logic                lfsr_load,
    output logic [3:0]          lfsr_seed,
    input  logic                lfsr_q,
    output logic [WORD_W-1:0]   word,
    output logic [IDX_W-1:0]    word_id,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                busy
);

    localparam int CNT_W = clog2(WORD_W + 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  win_r;
    logic [3:0]        seed_r;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] shreg;

    logic [NREQ-1:0]   arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld;
    logic [3:0]        seed_pick;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    always_comb begin
        seed_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                seed_pick = seed_pick | seed[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            win_r  <= '0;
            seed_r <= '0;
            cnt    <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        win_r  <= arb_idx;
                        seed_r <= sanitize_seed(seed_pick);
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    // The cell advances on this same edge, so lfsr_q is the
                    // output of the state being replaced.
                    shreg <= (shreg << 1) | WORD_W'(lfsr_q);
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WORD_W - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (word_ready) begin
                        ptr   <= (win_r == IDX_W'(NREQ - 1)) ? '0 : win_r + IDX_W'(1);
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (state == ST_LOAD) begin
            gnt[win_r] = 1'b1;
        end
    end

    assign lfsr_load  = (state == ST_LOAD);
    assign lfsr_seed  = seed_r;
    assign word       = shreg;
    assign word_id    = win_r;
    assign word_valid = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_lfsr_word_scheduler.sv
// Scoreboard bench for lfsr_word_scheduler with a behavioural 4-bit LFSR cell
// (shift left, feedback s[3]^s[2]) standing in for the parent's instance.
module tb_lfsr_word_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] seed;
    logic [3:0]  gnt;
    logic        lfsr_load;
    logic [3:0]  lfsr_seed;
    logic        lfsr_q;
    logic [7:0]  word;
    logic [1:0]  word_id;
    logic        word_valid;
    logic        word_ready;
    logic        busy;

    logic [3:0]  lfsr_s = 4'h0;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] s;
    } gexp_t;

    typedef struct packed {
        logic [7:0] w;
        logic [1:0] id;
    } wexp_t;

    gexp_t gq[$];
    wexp_t wq[$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (lfsr_load) lfsr_s <= lfsr_seed;
        else           lfsr_s <= {lfsr_s[2:0], lfsr_s[3] ^ lfsr_s[2]};
    end
    assign lfsr_q = lfsr_s[3] ^ lfsr_s[2];

    lfsr_word_scheduler #(
        .NREQ   (4),
        .WORD_W (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .seed       (seed),
        .gnt        (gnt),
        .lfsr_load  (lfsr_load),
        .lfsr_seed  (lfsr_seed),
        .lfsr_q     (lfsr_q),
        .word       (word),
        .word_id    (word_id),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_grant(input logic [3:0] g, input logic [3:0] s);
        gexp_t e;
        e.g = g;
        e.s = s;
        gq.push_back(e);
    endtask

    task automatic expect_word(input logic [7:0] w, input logic [1:0] id);
        wexp_t e;
        e.w  = w;
        e.id = id;
        wq.push_back(e);
    endtask

    task automatic monitor();
        gexp_t g;
        wexp_t w;
        forever begin
            @(negedge clock);
            if (gnt != 4'b0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 32'h0);
                end else begin
                    g = gq.pop_front();
                    chk("gnt", 32'(gnt), 32'(g.g));
                    chk("load_seed", 32'(lfsr_seed), 32'(g.s));
                    chk("lfsr_load", 32'(lfsr_load), 32'h1);
                end
            end
            if (word_valid && word_ready) begin
                if (wq.size() == 0) begin
                    chk("unexpected_word", 32'(word_valid), 32'h0);
                end else begin
                    w = wq.pop_front();
                    chk("word", 32'(word), 32'(w.w));
                    chk("word_id", 32'(word_id), 32'(w.id));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || word_valid) && t < 300) begin
            @(negedge clock);
            t++;
        end
        chk("idle_reached", 32'(busy), 32'h0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_gnt"},        32'(gnt),        32'h0);
        chk({tag, "_lfsr_load"},  32'(lfsr_load),  32'h0);
        chk({tag, "_lfsr_seed"},  32'(lfsr_seed),  32'h0);
        chk({tag, "_word"},       32'(word),       32'h0);
        chk({tag, "_word_id"},    32'(word_id),    32'h0);
        chk({tag, "_word_valid"}, 32'(word_valid), 32'h0);
        chk({tag, "_busy"},       32'(busy),       32'h0);
    endtask

    initial begin
        int e;
        int n;
        int t;

        reset      = 1'b0;
        req        = 4'b0;
        seed       = 16'h0;
        word_ready = 1'b1;

        fork
            monitor();
        join_none

        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b1;
        tick();

        // Single request, seed 1: word 0x35, valid present at the 10th edge.
        seed[3:0] = 4'h1;
        expect_grant(4'b0001, 4'h1);
        expect_word(8'h35, 2'd0);
        req = 4'b0001;
        @(posedge clock);
        #1 req = 4'b0;
        e = 0;
        while (e < 40) begin
            @(negedge clock);
            if (word_valid) break;
            @(posedge clock);
            e++;
        end
        chk("valid_edge", 32'(e + 1), 32'd10);
        wait_idle();

        // Zero seed on requester 2 is loaded as 1.
        seed[11:8] = 4'h0;
        expect_grant(4'b0100, 4'h1);
        expect_word(8'h35, 2'd2);
        req = 4'b0100;
        @(posedge clock);
        #1 req = 4'b0;
        wait_idle();

        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Round-robin from pointer 0 with all requests held.
        seed = {4'h8, 4'h4, 4'h2, 4'h1};
        expect_grant(4'b0001, 4'h1); expect_word(8'h35, 2'd0);
        expect_grant(4'b0010, 4'h2); expect_word(8'h6B, 2'd1);
        expect_grant(4'b0100, 4'h4); expect_word(8'hD7, 2'd2);
        expect_grant(4'b1000, 4'h8); expect_word(8'h9A, 2'd3);
        expect_grant(4'b0001, 4'h1); expect_word(8'h35, 2'd0);
        req = 4'b1111;
        n = 0;
        t = 0;
        while (n < 5 && t < 200) begin
            @(negedge clock);
            if (gnt != 4'b0) n++;
            t++;
        end
        req = 4'b0;
        chk("rr_grants", 32'(n), 32'd5);
        wait_idle();

        // Backpressure: result held for 20 cycles, then one transfer.
        seed[15:12] = 4'hF;
        word_ready  = 1'b0;
        expect_grant(4'b1000, 4'hF);
        expect_word(8'h13, 2'd3);
        req = 4'b1000;
        @(posedge clock);
        #1 req = 4'b0;
        t = 0;
        while (!word_valid && t < 40) begin
            @(negedge clock);
            t++;
        end
        chk("bp_valid", 32'(word_valid), 32'h1);
        repeat (20) begin
            @(negedge clock);
            chk("bp_word", 32'(word), 32'h13);
            chk("bp_id", 32'(word_id), 32'd3);
            chk("bp_busy", 32'(busy), 32'h1);
            chk("bp_gnt", 32'(gnt), 32'h0);
        end
        tick();
        word_ready = 1'b1;
        wait_idle();
        repeat (3) tick();
        chk("bp_single", 32'(wq.size()), 32'd0);

        // Request dropped during RUN still completes for requester 1.
        seed[7:4] = 4'h2;
        expect_grant(4'b0010, 4'h2);
        expect_word(8'h6B, 2'd1);
        req = 4'b0010;
        @(posedge clock);
        repeat (3) @(posedge clock);
        #1 req = 4'b0;
        wait_idle();

        // Reset in the middle of RUN discards the pending result.
        seed[11:8] = 4'h4;
        expect_grant(4'b0100, 4'h4);
        req = 4'b0100;
        @(posedge clock);
        #1 req = 4'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check_reset_values("midrun");
        tick();
        reset = 1'b1;
        tick();

        // Pointer back at 0: requester 1 wins over requester 3.
        seed[7:4]   = 4'h2;
        seed[15:12] = 4'h8;
        expect_grant(4'b0010, 4'h2);
        expect_word(8'h6B, 2'd1);
        req = 4'b1010;
        @(posedge clock);
        #1 req = 4'b0;
        wait_idle();
        repeat (3) tick();

        chk("gq_empty", 32'(gq.size()), 32'd0);
        chk("wq_empty", 32'(wq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
